mult_ajuste_ctrl: RTL



---
 rtl/mult_ajuste_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mult_ajuste_ctrl.sv
// mult_ajuste_ctrl: sequential 42x18 unsigned shift-add multiplier followed by
// an 18-bit window select acc[s+17:s] and a one-cycle done pulse.
// Optional build macro: MULT_AJUSTE_SAT_EN. When defined, a window that drops
// set bits above it saturates to 18'h3FFFF. When undefined, the window is
// truncated silently.
module mult_ajuste_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [41:0] a,
    input  logic [17:0] b,
    input  logic [5:0]  s,
    output logic        busy,
    output logic        done,
    output logic [17:0] y,
    output logic        err
);

    localparam int DATA_W = 42;                 // multiplicand width
    localparam int COEF_W = 18;                 // multiplier width
    localparam int PROD_W = DATA_W + COEF_W;    // full product width
    localparam int OUT_W  = 18;                 // result window width
    localparam logic [5:0] S_MAX     = 6'd42;   // largest legal window shift
    localparam logic [4:0] LAST_ITER = 5'd17;   // one iteration per multiplier bit

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_ADJ,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PROD_W-1:0]   a_q,   a_d;
    logic [COEF_W-1:0]   b_q,   b_d;
    logic [5:0]          s_q,   s_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [OUT_W-1:0]    y_q,   y_d;
    logic                err_q, err_d;
    logic                accept;

    // Plain window: bits below the shift are truncated, bits above are dropped.
    function automatic logic [OUT_W-1:0] window_trunc(input logic [PROD_W-1:0] acc_v,
                                                      input logic [5:0]        sh);
        logic [PROD_W-1:0] shifted;
        shifted = acc_v >> sh;
        return shifted[OUT_W-1:0];
    endfunction

`ifdef MULT_AJUSTE_SAT_EN
    // Saturating window: any set bit above the window clamps to full scale.
    function automatic logic [OUT_W-1:0] window_sat(input logic [PROD_W-1:0] acc_v,
                                                    input logic [5:0]        sh);
        logic [PROD_W-1:0] shifted;
        shifted = acc_v >> sh;
        if (|shifted[PROD_W-1:OUT_W]) begin
            return {OUT_W{1'b1}};
        end
        return shifted[OUT_W-1:0];
    endfunction
`endif

    // A request is taken while idle, and also in the done cycle so that a
    // continuously asserted start gives one result every 20 cycles.
    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state and datapath update for the four-phase schedule.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    a_d     = {{COEF_W{1'b0}}, a};
                    b_d     = b;
                    s_d     = s;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MULT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MULT: begin
                // One multiplier bit per cycle, always all 18 bits.
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_ADJ;
                end
            end

            ST_ADJ: begin
                if (s_q <= S_MAX) begin
`ifdef MULT_AJUSTE_SAT_EN
                    y_d = window_sat(acc_q, s_q);
`else
                    y_d = window_trunc(acc_q, s_q);
`endif
                    err_d = 1'b0;
                end else begin
                    y_d   = '0;
                    err_d = 1'b1;
                end
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and result registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign y    = y_q;
    assign err  = err_q;

endmodule
